// File: rtl/commit_trace_buffer.sv
// Retire-packet trace FIFO: stamps each retired instruction with a 64-bit order number and queues it for a trace consumer.
// Optional build macro TRACE_NOP_FILTER_EN drops canonical NOPs (addi x0,x0,0) before they reach the queue.
module commit_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     cpu_clk,
  input  logic                     reset,
  input  logic                     ret_valid,
  input  logic [31:0]              ret_insn,
  input  logic [31:0]              ret_pc_rdata,
  input  logic [31:0]              ret_pc_wdata,
  input  logic [4:0]               ret_rs1_addr,
  input  logic [31:0]              ret_rs1_rdata,
  input  logic [4:0]               ret_rs2_addr,
  input  logic [31:0]              ret_rs2_rdata,
  input  logic [4:0]               ret_rd_addr,
  input  logic [31:0]              ret_rd_wdata,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [270:0]             trc_pkt,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PKT_W = 271;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PKT_W-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [63:0]      order_r;

  logic             is_nop_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [AW:0]      fill_nxt_s;
  logic [31:0]      rd_wdata_s;
  logic [PKT_W-1:0] pkt_s;

`ifdef TRACE_NOP_FILTER_EN
  assign is_nop_s = (ret_insn == 32'h0000_0013);
`else
  assign is_nop_s = 1'b0;
`endif

  // Push/pop/drop decisions, next fill level and the packet to store.
  always_comb begin
    full_s     = (fill_level == FULL_LVL);
    pop_s      = trc_valid & trc_ready;
    push_s     = ret_valid & ~is_nop_s & (~full_s | pop_s);
    drop_s     = ret_valid & ~is_nop_s & full_s & ~pop_s;
    fill_nxt_s = fill_level;
    if (push_s && !pop_s) begin
      fill_nxt_s = fill_level + PTR_ONE;
    end else if (pop_s && !push_s) begin
      fill_nxt_s = fill_level - PTR_ONE;
    end else begin
      fill_nxt_s = fill_level;
    end
    // x0 writes never land, so the logged write-back value is forced to zero.
    if (ret_rd_addr == 5'd0) begin
      rd_wdata_s = 32'h0000_0000;
    end else begin
      rd_wdata_s = ret_rd_wdata;
    end
    pkt_s = {order_r, ret_insn, ret_pc_rdata, ret_pc_wdata,
             ret_rs1_addr, ret_rs1_rdata, ret_rs2_addr, ret_rs2_rdata,
             ret_rd_addr, rd_wdata_s};
  end

  // Pointers, occupancy, order stamp and overflow accounting.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fill_level <= '0;
      trc_valid  <= 1'b0;
      order_r    <= 64'd0;
      drop_cnt   <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      fill_level <= fill_nxt_s;
      trc_valid  <= (fill_nxt_s != '0);
      // Order advances on every retire, so downstream gaps reveal drops and filtered NOPs.
      if (ret_valid) order_r <= order_r + 64'd1;
      if (drop_s) begin
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
        ovf <= 1'b1;
      end
    end
  end

  // Packet storage; no reset needed since occupancy gates visibility.
  always_ff @(posedge cpu_clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r[AW-1:0]] <= pkt_s;
    end
  end

  assign trc_pkt = mem_r[rd_ptr_r[AW-1:0]];

endmodule
